gshare_pht: RTL
===============

# gshare_pht

Parametrised gshare branch direction predictor, the successor to the fixed 256-entry bimodal PHT. It indexes a table of saturating counters with PC bits XORed against a speculative global history register (GHR). It restores that history on a misprediction, and it initialises the whole table in hardware after reset. It sits beside the BTB in the fetch stage; updates arrive from the branch-resolve stage.

## Interface
- `PC_WIDTH`, 16, width of PC ports
- `PC_LSB`, 2, lowest PC bit used for indexing (word-aligned instructions)
- `INDEX_BITS`, 8, table index width; depth = 2^INDEX_BITS
- `HIST_BITS`, 8, GHR width; legal range 1..INDEX_BITS
- `CTR_BITS`, 2, saturating counter width; legal range ≥1

- `clk`  in  1  single clock, all state updates on posedge
- `rst`  in  1  reset, asynchronous, active-high
- `PC`  in  PC_WIDTH  fetch PC to predict
- `pred_en`  in  1  fetch slot holds a conditional branch; shift the prediction into the GHR
- `is_taken_predict`  out  1  predicted direction for `PC`
- `ghr_snapshot`  out  HIST_BITS  GHR used for the current prediction; travels with the branch
- `we`  in  1  resolved-branch update strobe
- `PC_actual`  in  PC_WIDTH  PC of the resolved branch
- `ghr_actual`  in  HIST_BITS  snapshot captured when that branch was predicted
- `is_taken_actual`  in  1  resolved direction
- `mispredict`  in  1  resolved direction differed from prediction; valid only with `we`
- `init_busy`  out  1  table initialisation sweep in progress

## Operation
- Read index = `PC[PC_LSB+INDEX_BITS-1:PC_LSB]` XOR zero-extended GHR. Write index = the same function of `PC_actual` and `ghr_actual`.
- Prediction = MSB of the addressed counter. The read is combinational from the array.
- Counter update, taken: increment, saturating at all-ones. Not taken: decrement, saturating at 0.
- GHR shift: `{ghr[HIST_BITS-2:0], bit}`. When HIST_BITS=1, the GHR is simply replaced by `bit`.
- Speculative path: when `pred_en`=1, the GHR shifts in `is_taken_predict`.
- Repair path: when `we`=1 and `mispredict`=1, GHR ← shift of `ghr_actual` with `is_taken_actual`. This takes priority over `pred_en` in the same cycle.
- `mispredict` without `we` is ignored.
- FSM states:
  - RESET: entered while `rst`=1. GHR=0, sweep counter=0, `init_busy`=1.
  - INIT: entered after `rst` falls. Writes weak-not-taken (2^(CTR_BITS-1)-1) to entry `sweep_cnt` each cycle and increments the counter. Moves to RUN after the write of entry 2^INDEX_BITS-1.
  - RUN: `init_busy`=0; normal operation.
- During RESET/INIT:
  - `is_taken_predict` forced 0.
  - `we`, `mispredict` and `pred_en` are ignored.
  - GHR is held at 0.
- Asserting `rst` in any state returns immediately to RESET. The sweep restarts from entry 0.

## Timing
- Reset values: `is_taken_predict`=0, `ghr_snapshot`=0, `init_busy`=1.
- Prediction has zero-cycle latency, combinational from `PC` and the current GHR.
- `ghr_snapshot` is the pre-shift GHR of the same cycle.
- A GHR change from `pred_en` or repair is visible on the cycle after the enabling edge.
- Counter writes occur at posedge. A same-cycle read of the entry being written returns the old value; the new value is visible next cycle.
- Init sweep lasts exactly 2^INDEX_BITS cycles after `rst` deasserts. `init_busy` falls on the cycle after the final entry is written.
- Back-to-back `we` to the same index on consecutive cycles must compound: each update reads the prior write.

## Structure
- Shared package `bp_pkg`:
  - counter helpers (weak-not-taken constant, `CTR_BITS`-generic)
  - index-hash function
  - FSM state enum (RESET/INIT/RUN)
- One sub-module, `sat_ctr_next` (combinational): inputs current count and direction; output is the next count. It is reused by later predictors.
- Counter table is a plain register array, with no vendor RAM macro.

## Test plan
- Reset/init: hold `rst` 3 cycles, release → `init_busy`=1 for 256 cycles, then 0. Every PC predicts 0. A `we` pulse during the sweep leaves the entry at 01.
- Training: `PC_actual`=0x0040, `ghr_actual`=0, two taken updates → entry 0x10 goes 01→10→11. With `PC`=0x0040 and GHR=0, `is_taken_predict`=1 from the cycle after the first update.
- Saturation/back-to-back: five consecutive taken `we` on 0x10, then one not-taken → counter 11, then 10, and prediction stays 1. Then two not-taken → 00, predict 0.
- Speculative history: `pred_en` over three cycles with predictions 1,0,1 from GHR=0 → GHR=0x05. `PC`=0x0040 now reads index 0x15 and `ghr_snapshot`=0x05.
- Repair priority: GHR=0x05, same cycle `pred_en`=1, `we`=1, `mispredict`=1, `ghr_actual`=0x3C, `is_taken_actual`=1 → GHR=0x79 next cycle. `pred_en` is ignored.
- Reset mid-sweep: assert `rst` at sweep entry 100 → GHR=0, `init_busy` stays 1. After release the sweep takes a full 256 cycles again, and entry 200 (previously trained to 11) reads 01.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: FSM states, counter constants and
// the gshare index hash, reused by the predictor family.
package bp_pkg;

    localparam int HASH_W = 32;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_INIT,
        ST_RUN
    } bp_state_e;

    // Weak-not-taken value for a counter of ctr_bits: 2^(ctr_bits-1)-1.
    function automatic int unsigned ctr_weak_nt(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

    // Callers zero-extend both operands and keep the low index bits.
    function automatic logic [HASH_W-1:0] pht_hash(input logic [HASH_W-1:0] pc_field,
                                                   input logic [HASH_W-1:0] hist);
        return pc_field ^ hist;
    endfunction

endpackage

// File: rtl/sat_ctr_next.sv
// Next-count logic for a W-bit saturating up/down direction counter.
module sat_ctr_next #(
    parameter int W = 2
) (
    input  logic [W-1:0] ctr,
    input  logic         taken,
    output logic [W-1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken && (ctr != '1)) begin
            ctr_next = ctr + 1'b1;
        end else if (!taken && (ctr != '0)) begin
            ctr_next = ctr - 1'b1;
        end
    end

endmodule

// File: rtl/gshare_pht.sv
// Gshare direction predictor: PC xor speculative GHR indexes a table of
// saturating counters; GHR is repaired on mispredict; table swept after reset.
//
// state    | meaning
// ST_RESET | held by rst; first edge after release writes entry 0
// ST_INIT  | sweep writes weak-not-taken to entries 1..2^INDEX_BITS-1
// ST_RUN   | normal predict/update operation
module gshare_pht
    import bp_pkg::*;
#(
    parameter int PC_WIDTH   = 16,
    parameter int PC_LSB     = 2,
    parameter int INDEX_BITS = 8,
    parameter int HIST_BITS  = 8,
    parameter int CTR_BITS   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PC_WIDTH-1:0]  PC,
    input  logic                 pred_en,
    output logic                 is_taken_predict,
    output logic [HIST_BITS-1:0] ghr_snapshot,
    input  logic                 we,
    input  logic [PC_WIDTH-1:0]  PC_actual,
    input  logic [HIST_BITS-1:0] ghr_actual,
    input  logic                 is_taken_actual,
    input  logic                 mispredict,
    output logic                 init_busy
);

    localparam int DEPTH = 2 ** INDEX_BITS;
    localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'(ctr_weak_nt(CTR_BITS));

    if (HIST_BITS < 1 || HIST_BITS > INDEX_BITS || CTR_BITS < 1) begin : g_bad_params
        $error("gshare_pht: illegal HIST_BITS/CTR_BITS");
    end

    bp_state_e             state_q, state_d;
    logic [INDEX_BITS-1:0] sweep_cnt;
    logic                  sweep_we;
    logic                  run;

    logic [CTR_BITS-1:0]   pht [DEPTH];
    logic [CTR_BITS-1:0]   wr_cur, wr_next;

    logic [HIST_BITS-1:0]  ghr_q, ghr_spec, ghr_fix;

    logic [HASH_W-1:0]            rd_hash, wr_hash;
    logic [INDEX_BITS-1:0]        rd_idx, wr_idx;
    logic [HASH_W-INDEX_BITS-1:0] unused_rd_hi, unused_wr_hi;
    logic                         unused_pc_bits;

    assign rd_hash = pht_hash(HASH_W'(PC[PC_LSB +: INDEX_BITS]), HASH_W'(ghr_q));
    assign wr_hash = pht_hash(HASH_W'(PC_actual[PC_LSB +: INDEX_BITS]), HASH_W'(ghr_actual));
    assign {unused_rd_hi, rd_idx} = rd_hash;
    assign {unused_wr_hi, wr_idx} = wr_hash;
    assign unused_pc_bits = ^{PC, PC_actual};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RESET;
            sweep_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (sweep_we) begin
                sweep_cnt <= sweep_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sweep_we = 1'b0;
        run      = 1'b0;
        case (state_q)
            ST_RESET: begin
                sweep_we = 1'b1;
                state_d  = ST_INIT;
            end
            ST_INIT: begin
                sweep_we = 1'b1;
                if (sweep_cnt == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                run = 1'b1;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    assign init_busy        = !run;
    assign is_taken_predict = run & pht[rd_idx][CTR_BITS-1];
    assign ghr_snapshot     = ghr_q;

    if (HIST_BITS == 1) begin : g_hist1
        assign ghr_spec = is_taken_predict;
        assign ghr_fix  = is_taken_actual;
    end else begin : g_histn
        assign ghr_spec = {ghr_q[HIST_BITS-2:0], is_taken_predict};
        assign ghr_fix  = {ghr_actual[HIST_BITS-2:0], is_taken_actual};
    end

    // Repair wins over the speculative shift in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (!run) begin
            ghr_q <= '0;
        end else if (we && mispredict) begin
            ghr_q <= ghr_fix;
        end else if (pred_en) begin
            ghr_q <= ghr_spec;
        end
    end

    assign wr_cur = pht[wr_idx];

    sat_ctr_next #(
        .W(CTR_BITS)
    ) u_ctr_next (
        .ctr     (wr_cur),
        .taken   (is_taken_actual),
        .ctr_next(wr_next)
    );

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            pht[sweep_cnt] <= WEAK_NT;
        end else if (run && we) begin
            pht[wr_idx] <= wr_next;
        end
    end

endmodule
